// File: rtl/memory_ctrl_pkg.sv
// Shared types and default geometry for the memory_ctrl host-to-SRAM controller.
// The INIT state is used only when MEMORY_CTRL_INIT_EN is defined.
package memory_ctrl_pkg;

  localparam int DEF_AWIDTH = 5;
  localparam int DEF_DWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    INIT  = 2'd3
  } state_e;

endpackage

// File: rtl/memory_ctrl.sv
// Single-port memory controller: one host access per two cycles over a shared tri-state bus.
// Define MEMORY_CTRL_INIT_EN to zero-fill the whole memory after every reset.
module memory_ctrl
  import memory_ctrl_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DWIDTH-1:0] rd_data,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  inout  wire  [DWIDTH-1:0] mem_data
);

`ifdef MEMORY_CTRL_INIT_EN
  localparam state_e RST_STATE = INIT;
  // One extra bit so the terminal count is visible without wrapping the address.
  logic [AWIDTH:0] init_cnt_q, init_cnt_d;
`else
  localparam state_e RST_STATE = IDLE;
`endif

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              drive_en_q, drive_en_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DWIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    req_ready_d = 1'b0;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    drive_en_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
`ifdef MEMORY_CTRL_INIT_EN
    init_cnt_d  = init_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          mem_addr_d = req_addr;
          if (req_we) begin
            state_d    = WRITE;
            mem_wr_d   = 1'b1;
            drive_en_d = 1'b1;
            wdata_d    = req_wdata;
          end else begin
            state_d  = READ;
            mem_rd_d = 1'b1;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      WRITE: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      READ: begin
        // The memory drives the bus for the whole READ cycle; capture it on the way out.
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rd_valid_d  = 1'b1;
        rd_data_d   = mem_data;
      end
`ifdef MEMORY_CTRL_INIT_EN
      INIT: begin
        if (init_cnt_q[AWIDTH]) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          mem_wr_d   = 1'b1;
          drive_en_d = 1'b1;
          wdata_d    = '0;
          mem_addr_d = init_cnt_q[AWIDTH-1:0];
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      req_ready_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      drive_en_q  <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
`ifdef MEMORY_CTRL_INIT_EN
      init_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      drive_en_q  <= drive_en_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
`ifdef MEMORY_CTRL_INIT_EN
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  // drive_en_q and mem_rd_q are never set together, so the bus has one driver at most.
  assign mem_data = drive_en_q ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_memory_ctrl.sv
// Randomized self-checking bench for memory_ctrl with a behavioural memory and an access-level reference model.
// Build with +define+MEMORY_CTRL_INIT_EN to exercise the zero-fill after reset.
module tb_memory_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic          mem_rd;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  memory_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data)
  );

  // Behavioural single-port memory: asynchronous read while mem_rd, write on the clock edge.
  assign mem_data = mem_rd ? mem[mem_addr] : {DW{1'bz}};
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Access-level reference: each accepted request occupies one busy cycle, a read
  // returns the model's memory contents one cycle after acceptance.
  bit            mon_en = 1'b0;
  bit            acc_q, acc_we, rd_pend;
  logic [AW-1:0] acc_addr, last_addr;
  logic [DW-1:0] acc_wdata, rd_exp, last_rd;

  always @(negedge clk) begin
    if (mon_en) begin
      check("no_contention", {31'b0, mem_rd & dut.drive_en_q}, 0);
      if (acc_q) begin
        check("busy_ready", req_ready, 0);
        check("busy_wr", mem_wr, acc_we);
        check("busy_rd", mem_rd, !acc_we);
        check("busy_addr", mem_addr, acc_addr);
        if (acc_we) begin
          check("wr_bus", mem_data, acc_wdata);
          ref_mem[acc_addr] = acc_wdata;
        end
        last_addr = acc_addr;
      end else begin
        check("idle_ready", req_ready, 1);
        check("idle_wr", mem_wr, 0);
        check("idle_rd", mem_rd, 0);
        check("idle_addr_hold", mem_addr, last_addr);
      end
      check("rd_valid", rd_valid, rd_pend);
      if (rd_pend) last_rd = rd_exp;
      check("rd_data", rd_data, last_rd);
      rd_pend = acc_q && !acc_we;
      if (rd_pend) rd_exp = ref_mem[acc_addr];
      acc_q     = req_valid && req_ready;
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  task automatic start_mon();
    acc_q   = 1'b0;
    rd_pend = 1'b0;
    last_rd = '0;
`ifdef MEMORY_CTRL_INIT_EN
    last_addr = AW'(DEPTH - 1);
`else
    last_addr = '0;
`endif
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called at the negedge where rst_n was released; returns at a negedge with req_ready high.
  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      check({tag, "_no_rdv"}, rd_valid, 0);
      n++;
      @(negedge clk);
    end
    check({tag, "_ready_timeout"}, {31'b0, n < 100}, 1);
`ifdef MEMORY_CTRL_INIT_EN
    check({tag, "_init_busy"}, {31'b0, n >= DEPTH}, 1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
    check({tag, "_ready_first_edge"}, n, 0);
`endif
  endtask

  // Entered just after a posedge; returns just after the edge that accepted the request.
  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 20);
    check("accept_timeout", {31'b0, n < 20}, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end

    #2;
    check("rst_ready", req_ready, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_rdata", rd_data, 0);
    check("rst_bus_released", dut.drive_en_q, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("boot");
    start_mon();

    // Basic write/read with explicit latency check.
    issue(1'b1, 5'd5, 8'hA5);
    issue(1'b0, 5'd5, 8'h00);
    req_valid = 1'b0;
    @(negedge clk);
    check("rd_a5_not_yet", rd_valid, 0);
    @(negedge clk);
    check("rd_a5_valid", rd_valid, 1);
    check("rd_a5_data", rd_data, 8'hA5);
    @(posedge clk); #1;
    idle(2);

    // Address extremes back-to-back under continuous req_valid.
    issue(1'b1, 5'd0, 8'h11);
    issue(1'b1, 5'd31, 8'hEE);
    issue(1'b0, 5'd0, 8'h00);
    issue(1'b0, 5'd31, 8'h00);
    idle(1);
    check("rd_31_data", rd_data, 8'hEE);
    idle(2);

    // Request fields changing after acceptance must not affect the access.
    issue(1'b1, 5'd7, 8'h3C);
    req_valid = 1'b0;
    req_addr  = 5'd9;
    req_wdata = 8'hFF;
    idle(2);
    issue(1'b0, 5'd7, 8'h00);
    idle(1);
    check("late_change_rd7", rd_data, 8'h3C);
    issue(1'b0, 5'd9, 8'h00);
    idle(2);

    // Randomized traffic with occasional gaps.
    for (int k = 0; k < 80; k++) begin
      issue(1'($urandom), AW'($urandom), DW'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    // Reset in the cycle after a write is accepted.
    issue(1'b1, 5'd3, 8'h5A);
    req_valid = 1'b0;
    mon_en    = 1'b0;
    #1 rst_n  = 1'b0;
    #1;
    check("abort_wr", mem_wr, 0);
    check("abort_ready", req_ready, 0);
    check("abort_rdv", rd_valid, 0);
    check("abort_bus_released", dut.drive_en_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // The aborted write may or may not have landed; adopt whatever the memory holds.
    ref_mem[3] = mem[3];
    wait_ready("abort");
    start_mon();

    issue(1'b0, 5'd0, 8'h00);
    issue(1'b0, 5'd17, 8'h00);
    issue(1'b0, 5'd31, 8'h00);
    issue(1'b1, 5'd17, 8'hC3);
    issue(1'b0, 5'd17, 8'h00);
    idle(1);
    check("post_reset_rd17", rd_data, 8'hC3);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
